pulse_event_queue: RTL and testbench



---
 rtl/pulse_event_queue_pkg.sv | 15 +
 rtl/pulse_event_queue_sat_counter.sv | 51 +++++
 rtl/pulse_event_queue.sv | 110 +++++++++++
 tb/tb_pulse_event_queue.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_event_queue_pkg.sv
// Shared definitions for the pulse event queue.
//   peq_state_t : issue FSM state encoding (2 bits)
//   MIN_GAP     : minimum number of cycles from one sin pulse to the next
package pulse_event_queue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_ARM   = 2'b10,
        ST_WAIT  = 2'b11
    } peq_state_t;

    localparam int MIN_GAP = 4;

endpackage

// File: rtl/pulse_event_queue_sat_counter.sv
// Saturating up/down counter with synchronous clear.
//   clk1, rstn1 : clock, asynchronous active-low reset
//   inc, dec    : count up / down; both together leave the count unchanged
//   clr         : synchronous clear; an inc in the same cycle counts from zero
//   cnt         : current count
//   ovf         : strobe, an inc was refused because the count is at all-ones
module peq_sat_counter #(
    parameter int W = 4
) (
    input  logic         clk1,
    input  logic         rstn1,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    localparam logic [W-1:0] MAX  = {W{1'b1}};
    localparam logic [W-1:0] ZERO = {W{1'b0}};
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] base;
    logic [W-1:0] cnt_nxt;

    // Clear is applied first so that a coincident increment lands on zero.
    assign base = clr ? ZERO : cnt;
    assign ovf  = inc && !dec && (base == MAX);

    always_comb begin
        cnt_nxt = base;
        if (inc && !dec) begin
            if (base != MAX) begin
                cnt_nxt = base + ONE;
            end
        end else if (dec && !inc) begin
            if (base != ZERO) begin
                cnt_nxt = base - ONE;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rstn1) begin
        if (!rstn1) begin
            cnt <= ZERO;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/pulse_event_queue.sv
// Source-side event queue feeding a handshake pulse synchronizer. Events on
// ev_in are counted into a saturating pending counter and replayed one at a
// time as single-cycle sin pulses whenever the synchronizer is not busy.
//   clk1, rstn1 : source clock, asynchronous active-low reset
//   ev_in       : event strobe, one event per high cycle
//   busy        : synchronizer handshake in flight
//   clr         : clear overflow flag and drop counter
//   sin         : registered request pulse to the synchronizer
//   pending     : events accepted but not yet issued
//   overflow    : sticky, an event was dropped since reset or last clr
//   drop_cnt    : saturating count of dropped events
//   idle        : FSM in IDLE with nothing pending
//
// state | meaning
// IDLE  | waiting for pending!=0 with busy low
// ISSUE | sin high, pending decrements
// ARM   | blind cycle while busy rises in response to sin
// WAIT  | hold until busy falls
module pulse_event_queue
    import pulse_event_queue_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int DROP_W = 8
) (
    input  logic              clk1,
    input  logic              rstn1,
    input  logic              ev_in,
    input  logic              busy,
    input  logic              clr,
    output logic              sin,
    output logic [CNT_W-1:0]  pending,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              idle
);

    peq_state_t state;
    peq_state_t state_nxt;
    logic       issue;
    logic       pend_ovf;
    logic       drop_sat;

    assign issue = (state == ST_ISSUE);

    peq_sat_counter #(.W(CNT_W)) u_pending (
        .clk1  (clk1),
        .rstn1 (rstn1),
        .inc   (ev_in),
        .dec   (issue),
        .clr   (1'b0),
        .cnt   (pending),
        .ovf   (pend_ovf)
    );

    // A refused increment on the pending counter is exactly a dropped event.
    peq_sat_counter #(.W(DROP_W)) u_drops (
        .clk1  (clk1),
        .rstn1 (rstn1),
        .inc   (pend_ovf),
        .dec   (1'b0),
        .clr   (clr),
        .cnt   (drop_cnt),
        .ovf   (drop_sat)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if ((pending != '0) && !busy) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_ARM;
            ST_ARM:   state_nxt = ST_WAIT;
            ST_WAIT:  if (!busy) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // sin is registered from the next-state decode so it is high exactly
    // while the FSM sits in ISSUE, with no combinational path to the output.
    always_ff @(posedge clk1 or negedge rstn1) begin
        if (!rstn1) begin
            state <= ST_IDLE;
            sin   <= 1'b0;
        end else begin
            state <= state_nxt;
            sin   <= (state_nxt == ST_ISSUE);
        end
    end

    // A drop coinciding with clr leaves the flag set.
    always_ff @(posedge clk1 or negedge rstn1) begin
        if (!rstn1) begin
            overflow <= 1'b0;
        end else if (pend_ovf) begin
            overflow <= 1'b1;
        end else if (clr) begin
            overflow <= 1'b0;
        end
    end

    assign idle = (state == ST_IDLE) && (pending == '0);

    a_sin_single: assert property (@(posedge clk1) disable iff (!rstn1)
        sin |=> !sin);

    // The drop counter can only reach all-ones after drops that also set
    // the sticky flag, and clr resets both together.
    a_drop_sat_flag: assert property (@(posedge clk1) disable iff (!rstn1)
        drop_sat |-> overflow);

endmodule

// File: tb/tb_pulse_event_queue.sv
module tb_pulse_event_queue;
    import pulse_event_queue_pkg::*;

    localparam int PMAX = 15;
    localparam int DMAX = 255;

    logic       clk1 = 1'b0;
    logic       rstn1 = 1'b0;
    logic       ev_in = 1'b0;
    logic       busy = 1'b0;
    logic       clr = 1'b0;
    logic       sin;
    logic [3:0] pending;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       idle;

    pulse_event_queue #(.CNT_W(4), .DROP_W(8)) dut (
        .clk1     (clk1),
        .rstn1    (rstn1),
        .ev_in    (ev_in),
        .busy     (busy),
        .clr      (clr),
        .sin      (sin),
        .pending  (pending),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .idle     (idle)
    );

    always #5 clk1 = ~clk1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // ---------------- busy responder ----------------
    // mode 0: busy rises the cycle after sin and holds busy_len cycles
    // mode 1: busy forced high, mode 2: random, mode 3: never busy
    int busy_mode = 0;
    int busy_len  = 6;
    int brem      = 0;

    initial begin
        forever begin
            @(posedge clk1);
            #1;
            if (!rstn1) begin
                busy = 1'b0;
                brem = 0;
            end else begin
                case (busy_mode)
                    0: begin
                        if (brem > 0) begin
                            busy = 1'b1;
                            brem--;
                        end else begin
                            busy = 1'b0;
                        end
                        if (sin) brem = busy_len;
                    end
                    1: busy = 1'b1;
                    2: busy = 1'($urandom_range(0, 1));
                    default: busy = 1'b0;
                endcase
            end
        end
    end

    // ---------------- reference model ----------------
    // Issue rule: after a pulse at cycle L, the channel reopens once busy is
    // seen low on some cycle >= L+2; the next pulse goes out the cycle after
    // a later cycle on which the channel is open, busy is low and events wait.
    typedef struct {
        logic sin;
        int   pend;
        logic ovf;
        int   drop;
        logic idle;
    } exp_t;

    exp_t sb[$];

    int m_pend = 0, m_drop = 0, m_last = -100, m_cyc = 0;
    bit m_ovf = 0, m_open = 1;

    always @(posedge clk1) begin
        bit   dec, go, dropped;
        exp_t e;
        if (!rstn1) begin
            m_pend = 0; m_drop = 0; m_ovf = 0;
            m_open = 1; m_last = -100; m_cyc = 0;
        end else begin
            dec     = (m_cyc == m_last);
            go      = m_open && !busy && (m_pend > 0);
            dropped = 0;
            if ((m_cyc >= m_last + 2) && !busy) m_open = 1;
            if (go) begin
                m_open = 0;
                m_last = m_cyc + 1;
            end
            if (ev_in && !dec) begin
                if (m_pend < PMAX) begin
                    m_pend++;
                end else begin
                    dropped = 1;
                    m_ovf   = 1;
                    m_drop  = clr ? 1 : ((m_drop < DMAX) ? m_drop + 1 : DMAX);
                end
            end else if (dec && !ev_in) begin
                m_pend--;
            end
            if (clr && !dropped) begin
                m_ovf  = 0;
                m_drop = 0;
            end
            m_cyc++;
            e.sin  = go;
            e.pend = m_pend;
            e.ovf  = m_ovf;
            e.drop = m_drop;
            e.idle = m_open && (m_pend == 0);
            sb.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    int sin_count = 0;
    int mon_cyc   = 0;
    int last_sin  = -1000;
    int min_gap   = 1000;

    always @(negedge clk1) begin
        exp_t e;
        if (!rstn1) begin
            sb.delete();
            last_sin = -1000;
            chk("rst_sin", 32'(sin), 0);
            chk("rst_pending", 32'(pending), 0);
            chk("rst_overflow", 32'(overflow), 0);
            chk("rst_drop_cnt", 32'(drop_cnt), 0);
            chk("rst_idle", 32'(idle), 1);
        end else if (sb.size() > 0) begin
            mon_cyc++;
            e = sb.pop_front();
            chk("sb_sin", 32'(sin), 32'(e.sin));
            chk("sb_pending", 32'(pending), e.pend);
            chk("sb_overflow", 32'(overflow), 32'(e.ovf));
            chk("sb_drop_cnt", 32'(drop_cnt), e.drop);
            chk("sb_idle", 32'(idle), 32'(e.idle));
            if (sin === 1'b1) begin
                sin_count++;
                if (last_sin > -1000) begin
                    chk("sin_min_gap", 32'((mon_cyc - last_sin) >= MIN_GAP), 1);
                    if ((mon_cyc - last_sin) < min_gap) min_gap = mon_cyc - last_sin;
                end
                last_sin = mon_cyc;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle(input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (idle === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk(name, 32'(ok), 1);
    endtask

    task automatic wait_sins(input int target, input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (sin_count >= target) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk(name, 32'(ok), 1);
    endtask

    task automatic events(input int n);
        for (int i = 0; i < n; i++) begin
            ev_in = 1'b1;
            tick();
        end
        ev_in = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        int peak;
        bit hit;

        rstn1 = 1'b0;
        repeat (3) tick();
        rstn1 = 1'b1;
        tick();
        chk("reset_idle", 32'(idle), 1);
        chk("reset_pending", 32'(pending), 0);
        repeat (5) tick();

        // Single event: pending at t+1, sin at t+2 only, idle once busy falls.
        busy_mode = 0;
        busy_len  = 6;
        ev_in = 1'b1;
        tick();
        ev_in = 1'b0;
        chk("single_pending_t1", 32'(pending), 1);
        chk("single_sin_t1", 32'(sin), 0);
        tick();
        chk("single_sin_t2", 32'(sin), 1);
        tick();
        chk("single_sin_t3", 32'(sin), 0);
        chk("single_pending_t3", 32'(pending), 0);
        chk("single_idle_t3", 32'(idle), 0);
        repeat (6) tick();
        chk("single_idle_t9", 32'(idle), 0);
        tick();
        chk("single_idle_t10", 32'(idle), 1);

        // Burst of five. The first issue overlaps the burst, so the count
        // tops out at 4.
        repeat (3) tick();
        s0 = sin_count;
        min_gap = 1000;
        peak = 0;
        for (int i = 0; i < 5; i++) begin
            ev_in = 1'b1;
            tick();
            if (int'(pending) > peak) peak = int'(pending);
        end
        ev_in = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (int'(pending) > peak) peak = int'(pending);
            if (sin_count >= s0 + 5) break;
            tick();
        end
        wait_idle(40, "burst_idle_timeout");
        chk("burst_sin_count", 32'(sin_count - s0), 5);
        chk("burst_peak", 32'(peak), 4);
        chk("burst_gap_ge8", 32'(min_gap >= 8), 1);
        chk("burst_overflow", 32'(overflow), 0);
        chk("burst_pending_end", 32'(pending), 0);

        // Saturation with busy held high: 15 accepted, 5 dropped.
        busy_mode = 1;
        repeat (2) tick();
        events(20);
        tick();
        chk("sat_pending", 32'(pending), 15);
        chk("sat_drop_cnt", 32'(drop_cnt), 5);
        chk("sat_overflow", 32'(overflow), 1);
        chk("sat_no_sin", 32'(sin), 0);
        s0 = sin_count;
        busy_mode = 0;
        wait_sins(s0 + 15, 300, "sat_drain_timeout");
        wait_idle(40, "sat_idle_timeout");
        chk("sat_drain_count", 32'(sin_count - s0), 15);
        chk("sat_drain_pending", 32'(pending), 0);

        // Event coincident with ISSUE at full count: no change, no drop.
        busy_mode = 1;
        repeat (2) tick();
        events(15);
        tick();
        chk("coinc_pending_pre", 32'(pending), 15);
        busy_mode = 3;
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sin === 1'b1) begin
                hit = 1;
                break;
            end
        end
        chk("coinc_found_issue", 32'(hit), 1);
        ev_in = 1'b1;
        tick();
        ev_in = 1'b0;
        chk("coinc_pending", 32'(pending), 15);
        chk("coinc_drop_cnt", 32'(drop_cnt), 5);
        busy_mode = 0;
        wait_idle(300, "coinc_drain_timeout");

        // clr coincident with a drop keeps the drop; clr alone clears.
        busy_mode = 1;
        repeat (2) tick();
        events(15);
        ev_in = 1'b1;
        clr   = 1'b1;
        tick();
        ev_in = 1'b0;
        clr   = 1'b0;
        chk("clrdrop_overflow", 32'(overflow), 1);
        chk("clrdrop_drop_cnt", 32'(drop_cnt), 1);
        repeat (2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_overflow", 32'(overflow), 0);
        chk("clr_drop_cnt", 32'(drop_cnt), 0);
        chk("clr_keeps_pending", 32'(pending), 15);
        busy_mode = 0;
        wait_idle(300, "clr_drain_timeout");

        // Asynchronous reset while waiting on busy with 7 pending.
        repeat (3) tick();
        events(8);
        chk("rstwait_pending", 32'(pending), 7);
        chk("rstwait_busy_idle", 32'(idle), 0);
        rstn1 = 1'b0;
        #1;
        chk("async_sin", 32'(sin), 0);
        chk("async_pending", 32'(pending), 0);
        chk("async_overflow", 32'(overflow), 0);
        chk("async_drop_cnt", 32'(drop_cnt), 0);
        chk("async_idle", 32'(idle), 1);
        repeat (2) tick();
        rstn1 = 1'b1;
        s0 = sin_count;
        repeat (20) tick();
        chk("post_rst_no_sin", 32'(sin_count - s0), 0);
        ev_in = 1'b1;
        tick();
        ev_in = 1'b0;
        wait_sins(s0 + 1, 20, "post_rst_sin_timeout");
        wait_idle(40, "post_rst_idle_timeout");

        // Randomized segments against the reference model.
        for (int seg = 0; seg < 20; seg++) begin
            int p;
            busy_mode = $urandom_range(0, 3);
            busy_len  = $urandom_range(0, 8);
            p = (busy_mode == 1) ? 90 : $urandom_range(5, 70);
            for (int c = 0; c < 80; c++) begin
                ev_in = ($urandom_range(0, 99) < p);
                clr   = ($urandom_range(0, 49) == 0);
                tick();
            end
        end
        ev_in = 1'b0;
        clr   = 1'b0;
        busy_mode = 3;
        wait_idle(400, "final_drain_timeout");
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
